// File: rtl/fetch_pair_unit_if.sv
// fetch_pair_unit_if
// Instruction-memory read port between the fetch stage and the instruction memory.
//   imem_req_out    fetch -> mem   read request
//   imem_addr_out   fetch -> mem   pair address (fetch PC[8:1])
//   imem_gnt_in     mem -> fetch   request accepted this cycle
//   imem_rvalid_in  mem -> fetch   response valid, in request order
//   imem_rdata_in   mem -> fetch   [15:0] even word, [31:16] odd word
// The master modport is the fetch unit, the slave modport is the memory.
interface fetch_pair_unit_if;
   logic        imem_req_out;
   logic [7:0]  imem_addr_out;
   logic        imem_gnt_in;
   logic        imem_rvalid_in;
   logic [31:0] imem_rdata_in;

   modport master (
      output imem_req_out,
      output imem_addr_out,
      input  imem_gnt_in,
      input  imem_rvalid_in,
      input  imem_rdata_in
   );

   modport slave (
      input  imem_req_out,
      input  imem_addr_out,
      output imem_gnt_in,
      output imem_rvalid_in,
      output imem_rdata_in
   );
endinterface

// File: rtl/fetch_pair_unit.sv
// fetch_pair_unit
// Fetch stage feeding the branch-generation unit (BGU). Prefetches 2x16-bit
// instruction pairs from even PCs, buffers them in a small FIFO and presents
// the head pair with its PC. A non-sequential PC from the BGU or a stage-3
// delayed-branch redirect flushes the FIFO and discards in-flight responses.
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   stall_in          hold the head pair (no consume)
//   pc_next_in        BGU next PC for the head pair
//   redirect_in       delayed-branch redirect, highest priority after reset
//   redirect_pc_in    redirect target (bit0 ignored)
//   imem              instruction-memory port (master side)
//   PC_out, p0_IR_out, p1_IR_out   head pair and its PC (0 when empty)
//   pair_valid_out    FIFO non-empty
//   fetch_next_out    head consumed this cycle
module fetch_pair_unit #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall_in,
   input  logic [8:0]               pc_next_in,
   input  logic                     redirect_in,
   input  logic [8:0]               redirect_pc_in,
   fetch_pair_unit_if.master        imem,
   output logic [8:0]               PC_out,
   output logic [15:0]              p0_IR_out,
   output logic [15:0]              p1_IR_out,
   output logic                     pair_valid_out,
   output logic                     fetch_next_out
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Fetch PC is kept as a pair address; bit0 of every PC is implicitly 0.
   logic [7:0]        fpc_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [CNT_W-1:0]  outst_reg;
   logic [CNT_W-1:0]  drop_reg;
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [PTR_W-1:0]  tag_wr_ptr_reg;
   logic [PTR_W-1:0]  tag_rd_ptr_reg;

   logic [7:0]        pc_mem  [DEPTH];
   logic [31:0]       ir_mem  [DEPTH];
   logic [7:0]        tag_mem [DEPTH];

   logic [8:0]        head_pc;
   logic [8:0]        seq_pc;
   logic              mismatch;
   logic              flush;
   logic [7:0]        flush_addr;
   logic [CNT_W:0]    occupancy;
   logic              req;
   logic              grant;
   logic              push;
   logic              pop;
   logic              unused_bits;

   assign unused_bits    = redirect_pc_in[0];

   assign pair_valid_out = (count_reg != '0);
   assign head_pc        = {pc_mem[rd_ptr_reg], 1'b0};
   assign seq_pc         = head_pc + 9'd2;

   assign PC_out         = pair_valid_out ? head_pc : 9'd0;
   assign p0_IR_out      = pair_valid_out ? ir_mem[rd_ptr_reg][15:0]  : 16'd0;
   assign p1_IR_out      = pair_valid_out ? ir_mem[rd_ptr_reg][31:16] : 16'd0;

   assign fetch_next_out = pair_valid_out & ~stall_in & ~redirect_in;
   assign mismatch       = fetch_next_out & (pc_next_in != seq_pc);
   assign flush          = redirect_in | mismatch;
   assign flush_addr     = redirect_in ? redirect_pc_in[8:1] : pc_next_in[8:1];

   // Cap counts both in-flight and buffered pairs so a response always has a slot.
   assign occupancy      = {1'b0, outst_reg} + {1'b0, count_reg};
   // Gating with rst keeps req low while reset is held; the first request
   // goes out in the first cycle after release.
   assign req            = rst & ~flush & (occupancy < (CNT_W+1)'(DEPTH));
   assign grant          = req & imem.imem_gnt_in;

   assign imem.imem_req_out  = req;
   assign imem.imem_addr_out = fpc_reg;

   // A response arriving in a flush cycle is stale as well, hence ~flush.
   assign push           = imem.imem_rvalid_in & (drop_reg == '0) & ~flush;
   assign pop            = fetch_next_out & ~mismatch;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fpc_reg        <= '0;
         count_reg      <= '0;
         outst_reg      <= '0;
         drop_reg       <= '0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         tag_wr_ptr_reg <= '0;
         tag_rd_ptr_reg <= '0;
      end else begin
         // Granted requests always return, so the tag FIFO survives a flush
         // and is drained by the dropped responses too.
         if (grant) begin
            tag_wr_ptr_reg <= tag_wr_ptr_reg + PTR_W'(1);
         end
         if (imem.imem_rvalid_in) begin
            tag_rd_ptr_reg <= tag_rd_ptr_reg + PTR_W'(1);
         end
         outst_reg <= outst_reg + CNT_W'(grant) - CNT_W'(imem.imem_rvalid_in);

         if (flush) begin
            fpc_reg    <= flush_addr;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            // Everything still in flight after this cycle belongs to the old stream.
            drop_reg   <= outst_reg - CNT_W'(imem.imem_rvalid_in);
         end else begin
            if (grant) begin
               fpc_reg <= fpc_reg + 8'd1;
            end
            if (imem.imem_rvalid_in && (drop_reg != '0)) begin
               drop_reg <= drop_reg - CNT_W'(1);
            end
            if (push) begin
               wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   // Storage needs no reset: the head outputs are masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (grant) begin
         tag_mem[tag_wr_ptr_reg] <= fpc_reg;
      end
      if (push) begin
         pc_mem[wr_ptr_reg] <= tag_mem[tag_rd_ptr_reg];
         ir_mem[wr_ptr_reg] <= imem.imem_rdata_in;
      end
   end
endmodule

// File: tb/tb_fetch_pair_unit.sv
module tb_fetch_pair_unit;
   localparam int DEPTH = 2;
   localparam int CNT_W = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_in = 1'b0;
   logic [8:0]  pc_next_in = 9'd0;
   logic        redirect_in = 1'b0;
   logic [8:0]  redirect_pc_in = 9'd0;
   logic [8:0]  PC_out;
   logic [15:0] p0_IR_out;
   logic [15:0] p1_IR_out;
   logic        pair_valid_out;
   logic        fetch_next_out;

   fetch_pair_unit_if imem_bus();

   fetch_pair_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall_in       (stall_in),
      .pc_next_in     (pc_next_in),
      .redirect_in    (redirect_in),
      .redirect_pc_in (redirect_pc_in),
      .imem           (imem_bus),
      .PC_out         (PC_out),
      .p0_IR_out      (p0_IR_out),
      .p1_IR_out      (p1_IR_out),
      .pair_valid_out (pair_valid_out),
      .fetch_next_out (fetch_next_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] addr;
      logic [8:0] pc;
      int         due;
      bit         dropped;
   } mreq_t;

   mreq_t      mq[$];      // requests in flight in the memory model
   logic [8:0] rdyq[$];    // scoreboard: PCs expected at the head, in order
   logic [8:0] cons_q[$];  // PCs the DUT actually handed to the BGU
   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         lat = 1;
   bit         gnt_rand = 1'b0;
   bit         pc_ovr_en = 1'b0;
   logic [8:0] pc_ovr = 9'd0;
   logic [8:0] exp_fpc = 9'd0;
   int         max_occ = 0;
   int         first_gnt_cyc = -1;
   int         first_vld_cyc = -1;

   function automatic logic [15:0] w0(input logic [8:0] pc);
      return {4'hC, 3'b000, pc[8:1], 1'b0};
   endfunction

   function automatic logic [15:0] w1(input logic [8:0] pc);
      return {4'hD, 3'b000, pc[8:1], 1'b1};
   endfunction

   // One clock cycle: drive memory, settle, check, update model, advance.
   task automatic step();
      bit         rv;
      bit         gn;
      bit         fn;
      bit         mism;
      bit         flush;
      bit         ereq;
      logic [8:0] tgt;
      logic [8:0] seq;
      mreq_t      e;
      rv = (mq.size() > 0) && (mq[0].due <= cyc);
      gn = gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      imem_bus.imem_rvalid_in = rv;
      imem_bus.imem_rdata_in  = rv ? {w1({mq[0].addr, 1'b0}), w0({mq[0].addr, 1'b0})} : 32'h0;
      imem_bus.imem_gnt_in    = gn;
      #1;
      pc_next_in = pc_ovr_en ? pc_ovr : (PC_out + 9'd2);
      #3;
      fn    = (rdyq.size() > 0) && !stall_in && !redirect_in;
      seq   = (rdyq.size() > 0) ? rdyq[0] + 9'd2 : 9'd0;
      mism  = fn && (pc_next_in != seq);
      flush = redirect_in || mism;
      tgt   = redirect_in ? redirect_pc_in : pc_next_in;
      ereq  = !flush && ((mq.size() + rdyq.size()) < DEPTH);

      checks++;
      if (pair_valid_out !== (rdyq.size() > 0)) begin
         errors++;
         $display("FAIL pair_valid cyc=%0d got=%b exp=%b", cyc, pair_valid_out, rdyq.size() > 0);
      end
      checks++;
      if (fetch_next_out !== fn) begin
         errors++;
         $display("FAIL fetch_next cyc=%0d got=%b exp=%b", cyc, fetch_next_out, fn);
      end
      checks++;
      if (imem_bus.imem_req_out !== ereq) begin
         errors++;
         $display("FAIL req cyc=%0d got=%b exp=%b", cyc, imem_bus.imem_req_out, ereq);
      end
      if (rdyq.size() > 0) begin
         checks++;
         if (PC_out !== rdyq[0] || p0_IR_out !== w0(rdyq[0]) || p1_IR_out !== w1(rdyq[0])) begin
            errors++;
            $display("FAIL head cyc=%0d got pc=%h p0=%h p1=%h exp pc=%h p0=%h p1=%h",
                     cyc, PC_out, p0_IR_out, p1_IR_out, rdyq[0], w0(rdyq[0]), w1(rdyq[0]));
         end
         if (first_vld_cyc < 0) first_vld_cyc = cyc;
      end
      if (fetch_next_out === 1'b1) cons_q.push_back(PC_out);
      if (fn) void'(rdyq.pop_front());
      if (rv) begin
         e = mq.pop_front();
         if (!e.dropped && !flush) rdyq.push_back(e.pc);
      end
      if (flush) begin
         rdyq.delete();
         foreach (mq[i]) mq[i].dropped = 1'b1;
         exp_fpc = {tgt[8:1], 1'b0};
      end
      if (imem_bus.imem_req_out === 1'b1 && gn) begin
         checks++;
         if (imem_bus.imem_addr_out !== exp_fpc[8:1]) begin
            errors++;
            $display("FAIL addr cyc=%0d got=%h exp=%h", cyc, imem_bus.imem_addr_out, exp_fpc[8:1]);
         end
         mq.push_back('{addr: imem_bus.imem_addr_out, pc: exp_fpc, due: cyc + lat, dropped: 1'b0});
         if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
         exp_fpc = exp_fpc + 9'd2;
      end
      if (mq.size() + rdyq.size() > max_occ) max_occ = mq.size() + rdyq.size();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_cons(input int n, input string tag);
      int budget;
      budget = 0;
      while (cons_q.size() < n && budget < 300) begin
         step();
         budget++;
      end
      checks++;
      if (cons_q.size() < n) begin
         errors++;
         $display("FAIL %s timeout got=%0d pairs need=%0d", tag, cons_q.size(), n);
      end
   endtask

   // Asserts reset, checks outputs immediately, clears the model, releases on a negedge.
   task automatic do_reset();
      rst = 1'b0;
      #1;
      checks++;
      if (imem_bus.imem_req_out !== 1'b0 || imem_bus.imem_addr_out !== 8'h00 ||
          PC_out !== 9'h000 || p0_IR_out !== 16'h0 || p1_IR_out !== 16'h0 ||
          pair_valid_out !== 1'b0 || fetch_next_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got req=%b addr=%h pc=%h p0=%h p1=%h v=%b fn=%b exp all 0",
                  imem_bus.imem_req_out, imem_bus.imem_addr_out, PC_out, p0_IR_out, p1_IR_out,
                  pair_valid_out, fetch_next_out);
      end
      mq.delete();
      rdyq.delete();
      cons_q.delete();
      exp_fpc = 9'd0;
      stall_in = 1'b0;
      redirect_in = 1'b0;
      pc_ovr_en = 1'b0;
      gnt_rand = 1'b0;
      imem_bus.imem_rvalid_in = 1'b0;
      imem_bus.imem_gnt_in = 1'b0;
      imem_bus.imem_rdata_in = 32'h0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      cyc = 0;
      first_gnt_cyc = -1;
      first_vld_cyc = -1;
   endtask

   task automatic test_reset();
      do_reset();
      lat = 1;
      run_cons(6, "reset_seq");
      checks++;
      if (first_gnt_cyc !== 0) begin
         errors++;
         $display("FAIL first_req_cycle got=%0d exp=0", first_gnt_cyc);
      end
      checks++;
      if (first_vld_cyc - first_gnt_cyc !== 2) begin
         errors++;
         $display("FAIL latency got=%0d exp=2", first_vld_cyc - first_gnt_cyc);
      end
      for (int i = 0; i < 6; i++) begin
         if (cons_q.size() > i) begin
            checks++;
            if (cons_q[i] !== 9'(2 * i)) begin
               errors++;
               $display("FAIL reset_seq[%0d] got=%h exp=%h", i, cons_q[i], 9'(2 * i));
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [8:0]  hold_pc;
      logic [15:0] hold_p0;
      logic [15:0] hold_p1;
      int          k0;
      int          n;
      do_reset();
      lat = 1;
      n = 0;
      while (rdyq.size() == 0 && n < 20) begin step(); n++; end
      k0 = cons_q.size();
      stall_in = 1'b1;
      hold_pc = PC_out;
      hold_p0 = p0_IR_out;
      hold_p1 = p1_IR_out;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (PC_out !== hold_pc || p0_IR_out !== hold_p0 || p1_IR_out !== hold_p1) begin
            errors++;
            $display("FAIL stall_hold cyc=%0d got pc=%h exp=%h", cyc, PC_out, hold_pc);
         end
      end
      checks++;
      if (imem_bus.imem_req_out !== 1'b0 || pair_valid_out !== 1'b1) begin
         errors++;
         $display("FAIL stall_cap got req=%b valid=%b exp req=0 valid=1", imem_bus.imem_req_out, pair_valid_out);
      end
      stall_in = 1'b0;
      run_cons(k0 + 4, "stall_release");
      for (int i = 0; i < 4; i++) begin
         if (cons_q.size() > k0 + i) begin
            checks++;
            if (cons_q[k0 + i] !== hold_pc + 9'(2 * i)) begin
               errors++;
               $display("FAIL stall_seq[%0d] got=%h exp=%h", i, cons_q[k0 + i], hold_pc + 9'(2 * i));
            end
         end
      end
   endtask

   task automatic test_mismatch();
      int n;
      int base;
      do_reset();
      lat = 2;
      n = 0;
      while (!(rdyq.size() > 0 && rdyq[0] == 9'h010) && n < 100) begin step(); n++; end
      pc_ovr_en = 1'b1;
      pc_ovr = 9'h040;
      step();
      pc_ovr_en = 1'b0;
      base = cons_q.size();
      checks++;
      if (base == 0 || cons_q[base - 1] !== 9'h010) begin
         errors++;
         $display("FAIL mismatch_consume got=%h exp=010", (base > 0) ? cons_q[base - 1] : 9'h1FF);
      end
      run_cons(base + 2, "mismatch");
      if (cons_q.size() > base + 1) begin
         checks++;
         if (cons_q[base] !== 9'h040 || cons_q[base + 1] !== 9'h042) begin
            errors++;
            $display("FAIL mismatch_target got=%h,%h exp=040,042", cons_q[base], cons_q[base + 1]);
         end
      end
   endtask

   task automatic test_redirect();
      int n;
      int base;
      do_reset();
      lat = 3;
      n = 0;
      while (mq.size() != 2 && n < 50) begin step(); n++; end
      redirect_in = 1'b1;
      redirect_pc_in = 9'h0A1;
      step();
      redirect_in = 1'b0;
      base = cons_q.size();
      run_cons(base + 2, "redirect");
      if (cons_q.size() > base + 1) begin
         checks++;
         if (cons_q[base] !== 9'h0A0 || cons_q[base + 1] !== 9'h0A2) begin
            errors++;
            $display("FAIL redirect_target got=%h,%h exp=0a0,0a2", cons_q[base], cons_q[base + 1]);
         end
      end
      // Redirect while stalled with a valid head: redirect still wins.
      stall_in = 1'b1;
      n = 0;
      while (rdyq.size() == 0 && n < 20) begin step(); n++; end
      redirect_in = 1'b1;
      redirect_pc_in = 9'h0C4;
      step();
      redirect_in = 1'b0;
      stall_in = 1'b0;
      base = cons_q.size();
      run_cons(base + 1, "redirect_stall");
      if (cons_q.size() > base) begin
         checks++;
         if (cons_q[base] !== 9'h0C4) begin
            errors++;
            $display("FAIL redirect_stall got=%h exp=0c4", cons_q[base]);
         end
      end
   endtask

   task automatic test_wrap();
      int base;
      do_reset();
      lat = 1;
      redirect_in = 1'b1;
      redirect_pc_in = 9'h1FF;
      step();
      redirect_in = 1'b0;
      base = cons_q.size();
      run_cons(base + 3, "wrap");
      if (cons_q.size() > base + 2) begin
         checks++;
         if (cons_q[base] !== 9'h1FE || cons_q[base + 1] !== 9'h000 || cons_q[base + 2] !== 9'h002) begin
            errors++;
            $display("FAIL wrap got=%h,%h,%h exp=1fe,000,002", cons_q[base], cons_q[base + 1], cons_q[base + 2]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      do_reset();
      lat = 2;
      gnt_rand = 1'b1;
      n = 0;
      while (cons_q.size() < 30 && n < 600) begin
         stall_in = ($urandom_range(0, 3) == 0);
         step();
         n++;
      end
      stall_in = 1'b0;
      gnt_rand = 1'b0;
      checks++;
      if (cons_q.size() < 30) begin
         errors++;
         $display("FAIL b2b timeout got=%0d pairs need=30", cons_q.size());
      end
      for (int i = 1; i < cons_q.size(); i++) begin
         checks++;
         if (cons_q[i] !== cons_q[i - 1] + 9'd2) begin
            errors++;
            $display("FAIL b2b_seq[%0d] got=%h exp=%h", i, cons_q[i], cons_q[i - 1] + 9'd2);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      int n;
      do_reset();
      lat = 3;
      n = 0;
      while (mq.size() != 2 && n < 50) begin step(); n++; end
      do_reset();
      lat = 1;
      run_cons(2, "reset_mid");
      if (cons_q.size() > 1) begin
         checks++;
         if (cons_q[0] !== 9'h000 || cons_q[1] !== 9'h002) begin
            errors++;
            $display("FAIL reset_mid_seq got=%h,%h exp=000,002", cons_q[0], cons_q[1]);
         end
      end
   endtask

   initial begin
      imem_bus.imem_gnt_in = 1'b0;
      imem_bus.imem_rvalid_in = 1'b0;
      imem_bus.imem_rdata_in = 32'h0;
      #2;
      test_reset();
      test_stall();
      test_mismatch();
      test_redirect();
      test_wrap();
      test_back_to_back();
      test_reset_mid_burst();
      checks++;
      if (max_occ > DEPTH) begin
         errors++;
         $display("FAIL overflow got=%0d exp<=%0d", max_occ, DEPTH);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
